// File: rtl/joypad_event_ctrl.sv
// joypad_event_ctrl: debounced 4-button joypad with press-event FIFO on an Avalon-MM slave
module joypad_event_ctrl #(
    parameter int DEBOUNCE_W = 16,
    parameter int THRESH_RST = 50000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        read_n,
    input  logic        write_n,
    input  logic [31:0] writedata,
    input  logic [3:0]  btn_n,
    output logic [31:0] readdata,
    output logic        irq
);
    localparam logic [DEBOUNCE_W:0] ONE_X = 1;
    localparam logic [DEBOUNCE_W-1:0] ONE = 1;

    logic [3:0] r_sync1, r_sync2, r_stable, r_pending;
    logic [DEBOUNCE_W-1:0] r_cnt [4];
    logic [DEBOUNCE_W-1:0] r_thr;
    logic [1:0] r_fifo [4];
    logic [1:0] r_rd_ptr, r_wr_ptr, r_mask;
    logic [2:0] r_count;
    logic r_ovf;
    logic [31:0] r_readdata;

    logic [DEBOUNCE_W-1:0] w_thr;
    logic [3:0] w_s, w_hit, w_rise, w_clr;
    logic [1:0] w_code, w_head;
    logic w_wr, w_rd, w_push, w_pop, w_full, w_store, w_flush;
    logic [31:0] w_rdata;

    assign w_s     = ~r_sync2;
    assign w_thr   = (r_thr == '0) ? ONE : r_thr;
    assign w_wr    = chipselect & ~write_n;
    assign w_rd    = chipselect & ~read_n;
    assign w_flush = w_wr && address == 2'd3 && writedata[31];
    assign w_push  = |r_pending;
    assign w_full  = r_count == 3'd4;
    assign w_pop   = w_rd && address == 2'd1 && r_count != 3'd0;
    assign w_store = w_push && (!w_full || w_pop);
    assign w_head  = (r_count != 3'd0) ? r_fifo[r_rd_ptr] : 2'd0;
    assign readdata = r_readdata;
    assign irq     = (r_mask[0] & (r_count != 3'd0)) | (r_mask[1] & r_ovf);

    // per-button threshold hit, press edges and lowest-index pending selection
    always_comb begin
        w_hit = '0;
        for (int i = 0; i < 4; i++)
            w_hit[i] = (w_s[i] != r_stable[i]) && ({1'b0, r_cnt[i]} + ONE_X >= {1'b0, w_thr});
        w_rise  = w_hit & w_s;
        w_code  = r_pending[0] ? 2'd0 : r_pending[1] ? 2'd1 : r_pending[2] ? 2'd2 : 2'd3;
        w_clr   = w_push ? (4'b0001 << w_code) : 4'b0000;
        w_rdata = (address == 2'd0) ? {23'b0, r_ovf, 1'b0, r_count, r_stable} :
                  (address == 2'd1) ? {29'b0, w_head, w_count_nz(r_count)} :
                  (address == 2'd2) ? {30'b0, r_mask} : 32'(r_thr);
    end

    function automatic logic w_count_nz(input logic [2:0] c);
        return c != 3'd0;
    endfunction

    // two-flop synchroniser, debounce counters and stable state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1  <= 4'hF;
            r_sync2  <= 4'hF;
            r_stable <= '0;
            for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
        end else begin
            r_sync1  <= btn_n;
            r_sync2  <= r_sync1;
            r_stable <= r_stable ^ w_hit;
            for (int i = 0; i < 4; i++)
                r_cnt[i] <= (w_s[i] == r_stable[i] || w_hit[i]) ? '0 : r_cnt[i] + ONE;
        end
    end

    // pending press flags: set on stable rise, cleared when taken or flushed
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_pending <= '0;
        else r_pending <= w_flush ? 4'b0 : ((r_pending & ~w_clr) | w_rise);
    end

    // event FIFO with drop-on-full overflow; flush wins over push and pop
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) r_fifo[i] <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else if (w_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_store) begin
                r_fifo[r_wr_ptr] <= w_code;
                r_wr_ptr <= r_wr_ptr + 2'd1;
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + 2'd1;
            r_count <= r_count + {2'b0, w_store} - {2'b0, w_pop};
            if (w_push && !w_store) r_ovf <= 1'b1;
        end
    end

    // software-writable mask and threshold
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mask <= '0;
            r_thr  <= DEBOUNCE_W'(THRESH_RST);
        end else begin
            if (w_wr && address == 2'd2) r_mask <= writedata[1:0];
            if (w_wr && address == 2'd3) r_thr <= writedata[DEBOUNCE_W-1:0];
        end
    end

    // read data registered every cycle from pre-pop state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_readdata <= '0;
        else r_readdata <= w_rdata;
    end
endmodule

// File: tb/tb_joypad_event_ctrl.sv
// tb_joypad_event_ctrl: directed checks of debounce, event FIFO, overflow, irq and reset
module tb_joypad_event_ctrl;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        read_n = 1'b1;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [3:0]  btn_n = 4'hF;
    logic [31:0] readdata;
    logic        irq;
    int          n_checks = 0;
    int          n_pass = 0;
    logic [31:0] rd;

    joypad_event_ctrl dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .read_n(read_n), .write_n(write_n), .writedata(writedata), .btn_n(btn_n),
        .readdata(readdata), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1; address = 2'd0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        address = a; chipselect = 1'b1; read_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; read_n = 1'b1; address = 2'd0;
        d = readdata;
    endtask

    initial begin
        wait_cyc(3);
        check("reset_readdata", readdata, 32'h0);
        check("reset_irq", {31'b0, irq}, 32'h0);
        reset_n = 1'b1;
        wait_cyc(2);
        bus_read(2'd3, rd); check("thr_reset", rd, 32'd50000);
        bus_write(2'd3, 32'd3);
        bus_read(2'd3, rd); check("thr_set3", rd, 32'd3);

        btn_n = 4'b1101;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            if (k == 4) check("down_not_yet", readdata, 32'h000);
            if (k == 5) check("down_stable", readdata, 32'h002);
            if (k == 6) check("down_queued", readdata, 32'h012);
        end
        check("down_irq_masked", {31'b0, irq}, 32'h0);
        bus_read(2'd1, rd); check("down_event", rd, 32'h3);
        bus_read(2'd0, rd); check("down_popped", rd, 32'h002);
        btn_n = 4'hF; wait_cyc(10);
        bus_read(2'd0, rd); check("release_no_event", rd, 32'h000);

        bus_write(2'd2, 32'h1);
        btn_n = 4'b1110; wait_cyc(2); btn_n = 4'hF;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("glitch_irq", {31'b0, irq}, 32'h0);
        end
        bus_read(2'd0, rd); check("glitch_status", rd, 32'h000);

        btn_n = 4'b1011; wait_cyc(10);
        check("ne_irq_set", {31'b0, irq}, 32'h1);
        bus_read(2'd1, rd); check("left_event", rd, 32'h5);
        check("ne_irq_clear", {31'b0, irq}, 32'h0);
        bus_read(2'd0, rd); check("left_status", rd, 32'h004);
        btn_n = 4'hF; wait_cyc(10);
        bus_write(2'd2, 32'h0);

        btn_n = 4'b0000;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (k == 5) check("all_stable", readdata, 32'h00F);
            if (k >= 6) check($sformatf("all_count%0d", k - 5), readdata, 32'h00F | ((k - 5) << 4));
        end
        bus_read(2'd0, rd); check("all_full", rd, 32'h04F);
        btn_n = 4'hF; wait_cyc(10);
        bus_read(2'd0, rd); check("all_released", rd, 32'h040);

        btn_n = 4'b1110; wait_cyc(5);
        bus_read(2'd1, rd); check("full_poppush_head", rd, 32'h1);
        bus_read(2'd0, rd); check("full_poppush_count", rd, 32'h041);
        bus_read(2'd1, rd); check("head_advanced", rd, 32'h3);
        bus_read(2'd0, rd); check("after_pop", rd, 32'h031);
        btn_n = 4'hF; wait_cyc(10);
        btn_n = 4'b1101; wait_cyc(10);
        bus_read(2'd0, rd); check("refill", rd, 32'h042);
        btn_n = 4'hF; wait_cyc(10);

        bus_write(2'd2, 32'h2);
        check("ovf_irq_idle", {31'b0, irq}, 32'h0);
        btn_n = 4'b0111; wait_cyc(10);
        bus_read(2'd0, rd); check("ovf_status", rd, 32'h148);
        check("ovf_irq", {31'b0, irq}, 32'h1);
        bus_read(2'd1, rd); check("ovf_head", rd, 32'h5);
        bus_read(2'd0, rd); check("ovf_sticky", rd, 32'h138);
        bus_write(2'd3, 32'h8000_0003);
        bus_read(2'd0, rd); check("flush_status", rd, 32'h008);
        check("flush_irq", {31'b0, irq}, 32'h0);
        bus_read(2'd3, rd); check("flush_thr", rd, 32'd3);
        bus_read(2'd1, rd); check("empty_event", rd, 32'h0);
        bus_read(2'd0, rd); check("empty_pop", rd, 32'h008);

        btn_n = 4'hF; wait_cyc(10);
        bus_write(2'd3, 32'd0);
        bus_read(2'd3, rd); check("thr_zero", rd, 32'd0);
        btn_n = 4'b1101;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k == 2) check("thr0_not_yet", readdata[3:0], 32'h0);
            if (k == 3) check("thr0_stable", readdata[3:0], 32'h2);
        end
        btn_n = 4'hF; wait_cyc(10);

        bus_write(2'd3, 32'd3);
        bus_write(2'd2, 32'h1);
        btn_n = 4'b1011; wait_cyc(10);
        check("pre_reset_irq", {31'b0, irq}, 32'h1);
        btn_n = 4'b1010; wait_cyc(3);
        reset_n = 1'b0;
        #1;
        check("async_readdata", readdata, 32'h0);
        check("async_irq", {31'b0, irq}, 32'h0);
        btn_n = 4'hF;
        wait_cyc(3);
        reset_n = 1'b1;
        wait_cyc(12);
        bus_read(2'd0, rd); check("post_reset_status", rd, 32'h000);
        check("post_reset_irq", {31'b0, irq}, 32'h0);
        bus_read(2'd3, rd); check("post_reset_thr", rd, 32'd50000);
        bus_read(2'd2, rd); check("post_reset_mask", rd, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/joypad_event_ctrl.md
JOYPAD_EVENT_CTRL -- requirements
Module: joypad_event_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_W, default 16, giving the width of the debounce counter and threshold.
REQ-002 SHALL have parameter THRESH_RST, default 50000, giving the reset value of the debounce threshold.
REQ-003 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port address  input  2  Avalon-MM word address.
REQ-006 SHALL have port chipselect  input  1  slave select.
REQ-007 SHALL have port read_n  input  1  active-low read strobe.
REQ-008 SHALL have port write_n  input  1  active-low write strobe.
REQ-009 SHALL have port writedata  input  32  write data.
REQ-010 SHALL have port btn_n  input  4  raw buttons, active-low; bit 0 = up, 1 = down, 2 = left, 3 = right; asynchronous to clk.
REQ-011 SHALL have port readdata  output  32  registered read data.
REQ-012 SHALL have port irq  output  1  level interrupt.

Function
REQ-013 SHALL synchronise each btn_n bit through two flops and invert the result, giving sample s[i], where 1 = pressed.
REQ-014 SHALL debounce each button with its own counter: counter clears when s[i] == stable[i]; otherwise it increments; when it reaches thr, stable[i] <= s[i] and the counter clears.
REQ-015 SHALL treat thr = 0 as thr = 1.
REQ-016 SHALL set pending[i] on every stable[i] 0->1 transition; release generates no event.
REQ-017 SHALL push at most one event per cycle into a 4-deep FIFO of 2-bit codes, taking the lowest pending index first; that pending bit clears in the same cycle.
REQ-018 On a push with the FIFO full and no pop that cycle, SHALL drop the event, clear its pending bit and set sticky ovf.
REQ-019 On a simultaneous push and pop with the FIFO full, SHALL perform both, leaving count unchanged and ovf not set.
REQ-020 A pop with the FIFO empty SHALL have no effect.
REQ-021 Address 0 (STATUS, read-only) SHALL read [3:0] = stable, [6:4] = count (0..4), [8] = ovf, all other bits 0.
REQ-022 Address 1 (EVENT) SHALL read [0] = FIFO non-empty and [2:1] = head code (0 when empty); a cycle with chipselect & ~read_n at address 1 SHALL pop one entry; writes are ignored.
REQ-023 Address 2 (IRQ_MASK) SHALL be read/write on bits [1:0]: [0] enables the non-empty interrupt, [1] enables the overflow interrupt.
REQ-024 Address 3 (CONTROL) SHALL read [DEBOUNCE_W-1:0] = thr.
REQ-025 A write to address 3 SHALL load thr from writedata[DEBOUNCE_W-1:0]; if writedata[31] = 1, the same write SHALL flush the FIFO, clear ovf and clear pending.
REQ-026 A flush SHALL take priority over a push or pop in the same cycle.
REQ-027 readdata SHALL be registered every cycle from address, giving a read latency of 1 cycle; the value SHALL reflect state before any pop in that cycle.
REQ-028 irq SHALL be combinational: irq = (mask[0] & count != 0) | (mask[1] & ovf).
REQ-029 A thr change SHALL take effect on the next cycle; counters already above the new thr SHALL complete on their next increment.

Reset
REQ-030 On reset_n low, asynchronously: readdata = 0, irq = 0, mask = 0, thr = THRESH_RST, ovf = 0, count = 0, pending = 0, stable = 0, debounce counters = 0, sync flops = 1 (released).
REQ-031 Reset asserted mid-debounce or with the FIFO non-empty SHALL discard all events; no event SHALL be generated by the reset release itself.

Verification
REQ-032 thr = 3; hold btn_n[1] low -> stable[1] rises 2 sync + 3 count cycles later; EVENT read returns 0x3 (valid, code 1); count goes to 0.
REQ-033 thr = 3; btn_n[0] glitches low for 2 cycles -> no stable change, count stays 0, irq stays 0.
REQ-034 btn_n[3:0] go low together -> FIFO holds codes 0, 1, 2, 3 in that order on consecutive cycles; STATUS[6:4] = 4.
REQ-035 FIFO full, mask = 0x2, fifth press -> ovf = 1 and irq = 1; write 0x80000003 to address 3 -> count = 0, ovf = 0, irq = 0, thr = 3.
REQ-036 FIFO full, pop coincides with a push -> count stays 4, ovf stays 0, head advances.
REQ-037 mask = 0x1, one event queued -> irq = 1; pop -> irq = 0 the cycle after the pop.
